edge_bitmap_writer: RTL and testbench

Upstream stage of the contour tracer. Accepts a raster-order stream of 1-bit foreground-mask pixels, builds a one-pixel-wide boundary map (foreground pixels with at least one background neighbour), and writes it to the shared edge BRAM. It writes one ROW_W-bit word per image row at address = row index, which is the format the contour tracer scans. A one-cycle `frame_done` pulse tells the tracer that a complete bitmap is in memory.

---
 rtl/edge_bitmap_writer.sv | 159 +++++++++++++++
 tb/tb_edge_bitmap_writer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/edge_bitmap_writer.sv
// Builds a one-pixel-wide boundary bitmap from a raster mask stream and writes one word per row.
// Optional build macro EDGE_8CONN_EN: interior test also requires the four diagonal neighbours.
module edge_bitmap_writer #(
    parameter int ROW_W  = 1024,
    parameter int ROWS   = 768,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_valid,
    input  logic              pix_in,
    input  logic              pix_sof,
    output logic              pix_ready,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [ROW_W-1:0]  bram_din,
    output logic              frame_done
);

    localparam int XW = (ROW_W > 1) ? $clog2(ROW_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WRITE,
        FLUSH,
        DONE
    } state_t;

    state_t            state;
    logic [XW-1:0]     x;
    logic [ADDR_W-1:0] y;
    logic [ROW_W-1:0]  row_a;
    logic [ROW_W-1:0]  row_b;
    logic [ROW_W-1:0]  row_c;
    logic [ROW_W-1:0]  row_c_next;
    logic [ROW_W-1:0]  edge_fill;
    logic [ROW_W-1:0]  edge_flush;
    logic              accept;
    logic              row_end;
    logic              last_row;

    // Shifting a row in zeros makes out-of-frame neighbours read as background.
    function automatic logic [ROW_W-1:0] edge_word(
        input logic [ROW_W-1:0] a,
        input logic [ROW_W-1:0] b,
        input logic [ROW_W-1:0] c
    );
        logic [ROW_W-1:0] interior;
        interior = a & c & (b << 1) & (b >> 1);
`ifdef EDGE_8CONN_EN
        interior = interior & (a << 1) & (a >> 1) & (c << 1) & (c >> 1);
`endif
        return b & ~interior;
    endfunction

    assign accept   = pix_valid & pix_ready;
    assign row_end  = (x == XW'(ROW_W - 1));
    assign last_row = (y == ADDR_W'(ROWS - 1));

    // NOTE: every always_comb output gets a full default first so no latch can be inferred.
    always_comb begin
        row_c_next    = row_c;
        row_c_next[x] = pix_in;
    end

    // The row being written on a row boundary already includes the pixel accepted this cycle.
    assign edge_fill  = edge_word(row_a, row_b, row_c_next);
    assign edge_flush = edge_word(row_a, row_b, '0);

    // NOTE: sequential state uses non-blocking assignments only; the row registers are
    // reset too because a frame must start from all-background neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            row_a      <= '0;
            row_b      <= '0;
            row_c      <= '0;
            pix_ready  <= 1'b0;
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_din   <= '0;
            frame_done <= 1'b0;
        end else begin
            bram_we    <= 1'b0;
            frame_done <= 1'b0;
            if (accept && pix_sof) begin
                // Start of frame, from IDLE or as an abort of the frame in progress.
                state     <= FILL;
                pix_ready <= 1'b1;
                row_a     <= '0;
                row_b     <= '0;
                row_c     <= {{(ROW_W - 1){1'b0}}, pix_in};
                x         <= XW'(1);
                y         <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        pix_ready <= 1'b1;
                    end
                    FILL: begin
                        if (accept) begin
                            row_c[x] <= pix_in;
                            if (!row_end) begin
                                x <= x + XW'(1);
                            end else begin
                                x <= '0;
                                if (y == '0) begin
                                    // Row 0 has no lower neighbour yet: shift without writing.
                                    row_a <= row_b;
                                    row_b <= row_c_next;
                                    row_c <= '0;
                                    y     <= ADDR_W'(1);
                                end else begin
                                    state     <= WRITE;
                                    pix_ready <= 1'b0;
                                    bram_we   <= 1'b1;
                                    bram_addr <= y - ADDR_W'(1);
                                    bram_din  <= edge_fill;
                                end
                            end
                        end
                    end
                    WRITE: begin
                        row_a <= row_b;
                        row_b <= row_c;
                        row_c <= '0;
                        if (last_row) begin
                            state <= FLUSH;
                        end else begin
                            y         <= y + ADDR_W'(1);
                            state     <= FILL;
                            pix_ready <= 1'b1;
                        end
                    end
                    FLUSH: begin
                        // Last row has no row below it; its strobe lands in the DONE cycle.
                        state      <= DONE;
                        bram_we    <= 1'b1;
                        bram_addr  <= ADDR_W'(ROWS - 1);
                        bram_din   <= edge_flush;
                        frame_done <= 1'b1;
                    end
                    DONE: begin
                        state     <= IDLE;
                        pix_ready <= 1'b1;
                    end
                    default: begin
                        state     <= IDLE;
                        pix_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_edge_bitmap_writer.sv
// Directed bench for edge_bitmap_writer at ROW_W=8, ROWS=4 with hand-computed edge words.
module tb_edge_bitmap_writer;

    localparam int ROW_W  = 8;
    localparam int ROWS   = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pix_valid = 1'b0;
    logic              pix_in = 1'b0;
    logic              pix_sof = 1'b0;
    logic              pix_ready;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [ROW_W-1:0]  bram_din;
    logic              frame_done;

    edge_bitmap_writer #(
        .ROW_W (ROW_W),
        .ROWS  (ROWS),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_valid (pix_valid),
        .pix_in    (pix_in),
        .pix_sof   (pix_sof),
        .pix_ready (pix_ready),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W-1:0] wa[$];
    logic [ROW_W-1:0]  wd[$];
    int   fd_cnt  = 0;
    int   consec  = 0;
    logic prev_we = 1'b0;

    // Write/frame_done monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (bram_we) begin
            wa.push_back(bram_addr);
            wd.push_back(bram_din);
        end
        if (bram_we && prev_we) consec++;
        prev_we = bram_we;
        if (frame_done) fd_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic p, input logic s);
        int budget;
        pix_valid = 1'b1;
        pix_in    = p;
        pix_sof   = s;
        budget    = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!pix_ready && budget < 50);
        if (!pix_ready) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        pix_valid = 1'b0;
        pix_in    = ~pix_in;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [31:0] img, input bit gaps);
        for (int yy = 0; yy < ROWS; yy++) begin
            for (int xx = 0; xx < ROW_W; xx++) begin
                if (gaps && ((xx + yy) % 3 == 0)) idle(1 + (xx % 2));
                push(img[ROW_W*yy + xx], (yy == 0) && (xx == 0));
            end
        end
    endtask

    task automatic check_frame(input string tag, input int base, input logic [31:0] exp);
        check({tag, "_nwr"}, wa.size() - base, 32'd4);
        if (wa.size() - base == 4) begin
            for (int i = 0; i < ROWS; i++) begin
                check($sformatf("%s_addr%0d", tag, i), 32'(wa[base+i]), i);
                check($sformatf("%s_din%0d", tag, i), 32'(wd[base+i]), 32'(exp[ROW_W*i +: ROW_W]));
            end
        end
    endtask

    // Image rows packed row 0 in the low byte; expected words packed addr 0 in the low byte.
    logic [31:0] sq_img, sq_exp, ones_img, ones_exp, diag_img, diag_exp;
    int base, fd0;

    initial begin
        sq_img   = 32'h1C1C1C00;
        sq_exp   = 32'h1C141C00;
        ones_img = 32'hFFFFFFFF;
        ones_exp = 32'hFF8181FF;
        diag_img = 32'hFFFFFBFF;
`ifdef EDGE_8CONN_EN
        diag_exp = 32'hFF8F8BFF;
`else
        diag_exp = 32'hFF858BFF;
`endif

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", pix_ready, 1'b0);
        check("rst_we", bram_we, 1'b0);
        check("rst_addr", bram_addr, 2'd0);
        check("rst_din", bram_din, 8'h00);
        check("rst_done", frame_done, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", pix_ready, 1'b1);

        // 3x3 square, continuous valid, with end-of-frame timing.
        base = wa.size();
        fd0  = fd_cnt;
        send_frame(sq_img, 1'b0);
        check("sq_last_we", bram_we, 1'b1);
        check("sq_last_addr", bram_addr, 2'd2);
        check("sq_last_din", bram_din, 8'h14);
        check("sq_write_ready", pix_ready, 1'b0);
        @(posedge clk);
        #1;
        check("sq_flush_done", frame_done, 1'b0);
        check("sq_flush_we", bram_we, 1'b0);
        check("sq_flush_ready", pix_ready, 1'b0);
        @(posedge clk);
        #1;
        check("sq_done_pulse", frame_done, 1'b1);
        check("sq_done_we", bram_we, 1'b1);
        check("sq_done_addr", bram_addr, 2'd3);
        check("sq_done_ready", pix_ready, 1'b0);
        @(posedge clk);
        #1;
        check("sq_done_clear", frame_done, 1'b0);
        check("sq_idle_ready", pix_ready, 1'b1);
        idle(4);
        check_frame("sq", base, sq_exp);
        check("sq_fd_cnt", fd_cnt - fd0, 32'd1);

        // All-ones frame.
        base = wa.size();
        fd0  = fd_cnt;
        send_frame(ones_img, 1'b0);
        idle(6);
        check_frame("ones", base, ones_exp);
        check("ones_fd_cnt", fd_cnt - fd0, 32'd1);

        // Restart: sof on pixel (5,2); only row 0 of the aborted frame is written.
        base = wa.size();
        fd0  = fd_cnt;
        for (int i = 0; i < 2*ROW_W + 5; i++) push(1'b1, i == 0);
        for (int i = 0; i < ROW_W*ROWS; i++) push(sq_img[i], i == 0);
        idle(6);
        check("rs_nwr", wa.size() - base, 32'd5);
        if (wa.size() - base == 5) begin
            check("rs_abort_addr", 32'(wa[base]), 32'd0);
            check("rs_abort_din", 32'(wd[base]), 32'hFF);
            check_frame("rs", base + 1, sq_exp);
        end
        check("rs_fd_cnt", fd_cnt - fd0, 32'd1);

        // Valid gaps: same result as the gap-free square.
        base = wa.size();
        fd0  = fd_cnt;
        send_frame(sq_img, 1'b1);
        idle(6);
        check_frame("gap", base, sq_exp);
        check("gap_fd_cnt", fd_cnt - fd0, 32'd1);

        // Missing interior pixel (2,1).
        base = wa.size();
        send_frame(diag_img, 1'b0);
        idle(6);
        check_frame("diag", base, diag_exp);

        // Reset pulsed during the WRITE cycle.
        base = wa.size();
        for (int i = 0; i < 2*ROW_W; i++) push(1'b1, i == 0);
        check("mr_write_we", bram_we, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mr_we_async", bram_we, 1'b0);
        check("mr_ready_async", pix_ready, 1'b0);
        @(negedge clk);
        check("mr_we_low", bram_we, 1'b0);
        check("mr_ready_low", pix_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mr_ready_back", pix_ready, 1'b1);
        check("mr_addr_rst", bram_addr, 2'd0);
        for (int i = 0; i < 2*ROW_W; i++) push(1'b1, 1'b0);
        idle(6);
        check("mr_no_writes", wa.size() - base, 32'd0);
        send_frame(ones_img, 1'b0);
        idle(6);
        check_frame("mr_recover", base, ones_exp);

        check("no_consec_we", consec, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
